pid_pwm: RTL and testbench
==========================

# pid_pwm

Output stage that sits directly downstream of the PID controller and consumes its signed `pid_out` word. It converts the control value into a sign/magnitude PWM drive (direction bit plus duty-cycled pulse) with a programmable period. Duty and direction are double-buffered so they update only at period boundaries. A per-period strobe is emitted that the PID path uses as its sample tick.

## Interface
- `VAL_LENGTH`, 32, width of the signed control input (matches the PID output word)
- `CNT_WIDTH`, 16, width of the period counter and duty values

- `sys_clk`  in  1  system clock; all logic on rising edge
- `sys_rst`  in  1  synchronous, active-high reset
- `enable`  in  1  run PWM; low forces idle
- `period`  in  CNT_WIDTH  PWM period in `sys_clk` cycles (unsigned); values < 2 are treated as 2
- `ctrl_value`  in  VAL_LENGTH  signed control value (two's complement) from the PID stage
- `pwm`  out  1  duty-cycled drive, registered
- `dir`  out  1  drive direction, 1 = negative `ctrl_value`, registered
- `period_tick`  out  1  one-cycle pulse on the first cycle of every period, registered
- `duty_q`  out  CNT_WIDTH  duty currently in force (high cycles per period)

## Operation
- States: IDLE, LOAD, RUN.
- IDLE: counter = 0, `pwm` = 0, `period_tick` = 0. `dir` and `duty_q` hold their values. `enable` = 1 moves to LOAD.
- LOAD (one cycle): latch `period_l` = max(`period`, 2). Latch duty/dir per the mapping rules below. Counter = 0. Go to RUN.
- RUN: counter counts 0 .. `period_l`-1.
  - The cycle after counter = `period_l`-1 is a reload: counter returns to 0, and `period_l`, `duty_q` and `dir` are re-latched from the inputs sampled on the last cycle of the old period.
  - `period`/`ctrl_value` changes mid-period have no effect until the reload.
- Mapping (`pid_pwm_map`):
  - mag = |`ctrl_value`|, saturated at 2^(VAL_LENGTH-1)-1. The most-negative input gives max magnitude with no overflow.
  - duty = min(mag, `period_l`).
  - sign = `ctrl_value`[MSB].
- Direction-change brake:
  - At reload, if mag ≠ 0 and sign ≠ `dir` and the current `duty_q` ≠ 0: load `duty_q` = 0 and keep `dir`. This makes one full brake period.
  - If `duty_q` = 0 already, load `dir` = sign and the new duty.
- If mag = 0: `duty_q` = 0 and `dir` is unchanged.
- `pwm` is high for exactly `duty_q` cycles, starting on the cycle `period_tick` is high.
  - `duty_q` = `period_l`: constant high (100%).
  - `duty_q` = 0: constant low.
- `enable` falling in any state: next cycle state = IDLE, `pwm` = 0, counter = 0; the period is aborted.
- `sys_rst` (any state, including mid-period) has priority over `enable`. Next cycle: state IDLE, counter 0, all outputs 0.

## Timing
- Reset values: `pwm` = 0, `dir` = 0, `period_tick` = 0, `duty_q` = 0, state IDLE.
- `enable` rising at edge N: LOAD during cycle N+1; first `period_tick` and first `pwm` high cycle at N+2.
- `period_tick` spacing is exactly `period_l` cycles while in RUN.
- Input-to-output latency: a `ctrl_value` change takes effect at the next reload. Worst case is `period_l` + 1 cycles; no combinational input-to-output path.
- A period change takes effect at the same reload as duty, and duty is clamped against the new period.

## Structure
- Package `pid_pwm_pkg`:
  - state enum (IDLE, LOAD, RUN)
  - constant `PERIOD_MIN` = 2
  - reload-decision function (brake vs apply)
- Sub-module `pid_pwm_map`: combinational saturating abs, sign extraction and clamp to `period_l`.
- Top `pid_pwm`: FSM, counter, shadow registers and output registers.

## Test plan
- Reset mid-RUN with `period` = 10, `ctrl_value` = 4 → next cycle: all outputs 0, state IDLE; re-enable → first tick 2 cycles after `enable`.
- `period` = 10, `ctrl_value` = 3 → `period_tick` every 10 cycles, `pwm` high 3 / low 7, `dir` = 0, `duty_q` = 3.
- `ctrl_value` = 25 with `period` = 10 → `pwm` constant high, `duty_q` = 10. `ctrl_value` = -2^31 → `dir` = 1, `duty_q` = 10, no overflow.
- Running at +4, switch to -6 mid-period:
  - rest of current period unchanged;
  - next period `duty_q` = 0 with `dir` = 0 (brake);
  - following period `dir` = 1 and `duty_q` = 6.
- `period` = 0 and `period` = 1 → period 2 cycles. Change `period` 10→5 mid-period → old period completes at 10, then 5-cycle periods with duty clamped to 5.
- Drop `enable` at counter = 4 with duty 7 → `pwm` low next cycle, no further `period_tick`, `duty_q`/`dir` held.

Source files
------------

// File: rtl/pid_pwm_pkg.sv
// Shared types, constants and the reload decision for the PID-to-PWM output stage.
package pid_pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Shortest period the stage will run; smaller requests are raised to this.
  localparam int PERIOD_MIN = 2;

  // True when the next period must be a brake period: a nonzero command in the
  // opposite direction while the bridge is still driving.
  function automatic logic brake_needed(input logic mag_nz,
                                        input logic sign,
                                        input logic dir,
                                        input logic duty_nz);
    return mag_nz && (sign != dir) && duty_nz;
  endfunction

endpackage

// File: rtl/pid_pwm_map.sv
// Combinational mapping of the signed control word to direction and duty:
// saturating absolute value, sign extraction and clamp to the period length.
module pid_pwm_map #(
  parameter int VAL_LENGTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic [VAL_LENGTH-1:0] ctrl_value,
  input  logic [CNT_WIDTH-1:0]  period_l,
  output logic                  sign,
  output logic                  mag_nz,
  output logic [CNT_WIDTH-1:0]  duty
);

  logic [VAL_LENGTH-1:0] neg;
  logic [VAL_LENGTH-1:0] mag;
  logic [VAL_LENGTH-1:0] period_ext;

  // Magnitude with the most-negative input saturated to the largest positive value.
  always_comb begin
    sign       = ctrl_value[VAL_LENGTH-1];
    neg        = (~ctrl_value) + {{(VAL_LENGTH-1){1'b0}}, 1'b1};
    period_ext = {{(VAL_LENGTH-CNT_WIDTH){1'b0}}, period_l};
    if (!sign) begin
      mag = ctrl_value;
    end else if (neg[VAL_LENGTH-1]) begin
      // negating the most-negative value wraps back to itself
      mag = {1'b0, {(VAL_LENGTH-1){1'b1}}};
    end else begin
      mag = neg;
    end
    mag_nz = |mag;
    if (mag < period_ext) begin
      duty = mag[CNT_WIDTH-1:0];
    end else begin
      duty = period_l;
    end
  end

endmodule

// File: rtl/pid_pwm.sv
// Sign/magnitude PWM output stage: FSM, period counter, double-buffered
// duty/direction/period and registered pwm, dir and period_tick outputs.
module pid_pwm
  import pid_pwm_pkg::*;
#(
  parameter int VAL_LENGTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  enable,
  input  logic [CNT_WIDTH-1:0]  period,
  input  logic [VAL_LENGTH-1:0] ctrl_value,
  output logic                  pwm,
  output logic                  dir,
  output logic                  period_tick,
  output logic [CNT_WIDTH-1:0]  duty_q
);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] period_l;
  logic [CNT_WIDTH-1:0] period_next;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 last_cycle;
  logic                 map_sign;
  logic                 map_mag_nz;
  logic [CNT_WIDTH-1:0] map_duty;

  // Period request raised to the minimum, plus counter helpers.
  always_comb begin
    if (period < CNT_WIDTH'(PERIOD_MIN)) begin
      period_next = CNT_WIDTH'(PERIOD_MIN);
    end else begin
      period_next = period;
    end
    cnt_inc    = cnt + CNT_WIDTH'(1);
    last_cycle = (cnt == (period_l - CNT_WIDTH'(1)));
  end

  // Duty is clamped against the period that will be in force after the reload.
  pid_pwm_map #(
    .VAL_LENGTH(VAL_LENGTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_map (
    .ctrl_value(ctrl_value),
    .period_l  (period_next),
    .sign      (map_sign),
    .mag_nz    (map_mag_nz),
    .duty      (map_duty)
  );

  // FSM, counter, shadow registers and registered outputs; outputs always
  // describe the counter position the FSM is moving into.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      period_l    <= CNT_WIDTH'(PERIOD_MIN);
      pwm         <= 1'b0;
      dir         <= 1'b0;
      period_tick <= 1'b0;
      duty_q      <= '0;
    end else if (!enable) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      pwm         <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state       <= ST_LOAD;
          cnt         <= '0;
          pwm         <= 1'b0;
          period_tick <= 1'b0;
        end
        ST_LOAD: begin
          // drive was stopped while idle, so a direction change needs no brake
          state       <= ST_RUN;
          cnt         <= '0;
          period_l    <= period_next;
          period_tick <= 1'b1;
          if (map_mag_nz) begin
            duty_q <= map_duty;
            dir    <= map_sign;
            pwm    <= 1'b1;
          end else begin
            duty_q <= '0;
            pwm    <= 1'b0;
          end
        end
        ST_RUN: begin
          if (last_cycle) begin
            cnt         <= '0;
            period_l    <= period_next;
            period_tick <= 1'b1;
            if (!map_mag_nz || brake_needed(map_mag_nz, map_sign, dir, |duty_q)) begin
              duty_q <= '0;
              pwm    <= 1'b0;
            end else begin
              duty_q <= map_duty;
              dir    <= map_sign;
              pwm    <= 1'b1;
            end
          end else begin
            cnt         <= cnt_inc;
            period_tick <= 1'b0;
            pwm         <= (cnt_inc < duty_q);
          end
        end
        default: begin
          state       <= ST_IDLE;
          cnt         <= '0;
          pwm         <= 1'b0;
          period_tick <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pid_pwm.sv
// Randomized and directed bench for pid_pwm against a period-level reference model.
module tb_pid_pwm;

  logic        sys_clk;
  logic        sys_rst;
  logic        enable;
  logic [15:0] period;
  logic [31:0] ctrl_value;
  logic        pwm;
  logic        dir;
  logic        period_tick;
  logic [15:0] duty_q;

  int n_checks;
  int n_fail;

  // reference model: mode 0 idle, 1 load, 2 run; pos = position in period
  int       m_mode;
  int       m_pos;
  int       m_plen;
  longint   m_duty;
  bit       m_dir;

  pid_pwm #(.VAL_LENGTH(32), .CNT_WIDTH(16)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .enable     (enable),
    .period     (period),
    .ctrl_value (ctrl_value),
    .pwm        (pwm),
    .dir        (dir),
    .period_tick(period_tick),
    .duty_q     (duty_q)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // New period start: take period and command seen on the last cycle.
  task automatic model_start_period(input bit brake_allowed);
    longint v;
    longint mag;
    bit     sgn;
    m_plen = (period < 16'd2) ? 2 : int'(period);
    v      = longint'($signed(ctrl_value));
    mag    = (v < 0) ? -v : v;
    if (mag > 64'sd2147483647) mag = 64'sd2147483647;
    sgn    = (v < 0);
    if (mag == 0) begin
      m_duty = 0;
    end else if (brake_allowed && (sgn != m_dir) && (m_duty != 0)) begin
      m_duty = 0;
    end else begin
      m_duty = (mag < m_plen) ? mag : m_plen;
      m_dir  = sgn;
    end
  endtask

  task automatic model_update();
    if (sys_rst) begin
      m_mode = 0; m_pos = 0; m_duty = 0; m_dir = 1'b0; m_plen = 2;
    end else if (!enable) begin
      m_mode = 0; m_pos = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      model_start_period(1'b0);
      m_mode = 2; m_pos = 0;
    end else if (m_pos == m_plen - 1) begin
      model_start_period(1'b1);
      m_pos = 0;
    end else begin
      m_pos++;
    end
  endtask

  // One clock: model follows the edge, outputs compared half a cycle later.
  task automatic step();
    @(posedge sys_clk);
    model_update();
    @(negedge sys_clk);
    check_eq("pwm",  {31'd0, pwm},         {31'd0, (m_mode == 2) && (longint'(m_pos) < m_duty)});
    check_eq("tick", {31'd0, period_tick}, {31'd0, (m_mode == 2) && (m_pos == 0)});
    check_eq("dir",  {31'd0, dir},         {31'd0, m_dir});
    check_eq("duty", {16'd0, duty_q},      32'(m_duty));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the model sits at the given position in RUN (bounded).
  task automatic run_to_pos(input int p);
    int k;
    k = 0;
    while (!(m_mode == 2 && m_pos == p) && k < 100) begin
      step();
      k++;
    end
    check_eq("reach_pos", k < 100, 32'd1);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    m_mode = 0; m_pos = 0; m_plen = 2; m_duty = 0; m_dir = 1'b0;
    sys_rst = 1'b1; enable = 1'b0; period = 16'd10; ctrl_value = 32'd0;
    @(negedge sys_clk);
    run(2);
    check_eq("rst_pwm", {31'd0, pwm}, 32'd0);
    check_eq("rst_duty", {16'd0, duty_q}, 32'd0);
    sys_rst = 1'b0;

    // period 10, +3: 3 high / 7 low, dir 0
    ctrl_value = 32'd3; enable = 1'b1;
    run(32);
    check_eq("duty3", {16'd0, duty_q}, 32'd3);
    check_eq("dir3", {31'd0, dir}, 32'd0);

    // saturating duty, then most-negative input
    ctrl_value = 32'd25;
    run(25);
    check_eq("duty_sat", {16'd0, duty_q}, 32'd10);
    ctrl_value = 32'h8000_0000;
    run(25);
    check_eq("dir_minneg", {31'd0, dir}, 32'd1);
    check_eq("duty_minneg", {16'd0, duty_q}, 32'd10);

    // reset mid-run, then re-enable latency
    sys_rst = 1'b1; ctrl_value = 32'd0; enable = 1'b0;
    run(1);
    sys_rst = 1'b0; ctrl_value = 32'd4; enable = 1'b1;
    run(15);
    sys_rst = 1'b1;
    step();
    check_eq("mid_rst_pwm", {31'd0, pwm}, 32'd0);
    check_eq("mid_rst_tick", {31'd0, period_tick}, 32'd0);
    check_eq("mid_rst_duty", {16'd0, duty_q}, 32'd0);
    sys_rst = 1'b0; enable = 1'b0;
    step();
    enable = 1'b1;
    step();
    check_eq("load_tick", {31'd0, period_tick}, 32'd0);
    step();
    check_eq("first_tick", {31'd0, period_tick}, 32'd1);
    check_eq("first_pwm", {31'd0, pwm}, 32'd1);

    // +4 -> -6 mid-period: brake period then reverse
    run_to_pos(5);
    ctrl_value = -32'sd6;
    run_to_pos(0);
    check_eq("brake_duty", {16'd0, duty_q}, 32'd0);
    check_eq("brake_dir", {31'd0, dir}, 32'd0);
    run(10);
    check_eq("rev_dir", {31'd0, dir}, 32'd1);
    check_eq("rev_duty", {16'd0, duty_q}, 32'd6);

    // minimum period handling and shrink mid-period
    ctrl_value = 32'd1; period = 16'd0;
    run(24);
    period = 16'd1;
    run(12);
    period = 16'd10; ctrl_value = 32'd7;
    run(24);
    run_to_pos(3);
    period = 16'd5;
    run(20);
    check_eq("shrink_duty", {16'd0, duty_q}, 32'd5);

    // drop enable at counter 4 with duty 7
    period = 16'd10;
    run(24);
    run_to_pos(4);
    enable = 1'b0;
    run(12);
    check_eq("drop_duty", {16'd0, duty_q}, 32'd7);

    // random phase
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      sys_rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      if ($urandom_range(0, 39) == 0) period = 16'($urandom_range(0, 12));
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 5))
          0:       ctrl_value = 32'h8000_0000;
          1:       ctrl_value = 32'h7FFF_FFFF;
          2:       ctrl_value = 32'd0;
          default: ctrl_value = 32'($urandom_range(0, 30)) - 32'd15;
        endcase
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
